// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array cell: operation modes, controller
// states and the signed saturation helpers used by the result path.
package sa_pkg;

  typedef enum logic [1:0] {
    ModeLoad = 2'd0,
    ModeMac  = 2'd1,
    ModeElem = 2'd2,
    ModePass = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StHold  = 3'd4
  } state_e;

  // Widest value the saturation helpers accept; callers sign-extend into it.
  localparam int unsigned SatInWidth = 64;

  // Clamp a signed value into the range of a 'width'-bit signed number.
  function automatic logic signed [SatInWidth-1:0] sat_to_width(
    input logic signed [SatInWidth-1:0] value,
    input int unsigned                  width
  );
    logic signed [SatInWidth-1:0] hi;
    logic signed [SatInWidth-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

  // High when sat_to_width would have to clamp the value.
  function automatic logic sat_overflow(
    input logic signed [SatInWidth-1:0] value,
    input int unsigned                  width
  );
    logic signed [SatInWidth-1:0] hi;
    logic signed [SatInWidth-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    return (value > hi) || (value < lo);
  endfunction

endpackage

// File: rtl/sa_mult_pipe.sv
// Two-stage signed multiplier: operands are registered, then the full-width product.
// A common enable freezes both stages so a stalled consumer never loses a product.
module sa_mult_pipe #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic                      in_valid,
  output logic [2*DATA_WIDTH-1:0]   prod,
  output logic                      out_valid,
  output logic                      active
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  v1_q;
  logic [PW-1:0]         prod_q;
  logic                  v2_q;

  // Operand capture then product register, both held while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      v1_q   <= 1'b0;
      prod_q <= '0;
      v2_q   <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        prod_q <= PW'($signed(a_q)) * PW'($signed(b_q));
      end
    end
  end

  assign prod      = prod_q;
  assign out_valid = v2_q;
  assign active    = v1_q | v2_q;

endmodule

// File: rtl/sa_cell_pipe.sv
// Systolic-array processing cell: weight buffer, activation forwarding east, and a
// pipelined multiply feeding either an accumulator (MAC) or a result stream (ELEM).
module sa_cell_pipe
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter int unsigned WD_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic                          start,
  input  logic [$clog2(WD_DEPTH):0]     k_len,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_in_valid,
  input  logic [DATA_WIDTH-1:0]         left_in,
  input  logic                          left_valid,
  output logic                          left_ready,
  input  logic [DATA_WIDTH-1:0]         top_in,
  input  logic                          top_valid,
  output logic                          top_ready,
  output logic [DATA_WIDTH-1:0]         right_out,
  output logic                          right_valid,
  output logic [DATA_WIDTH-1:0]         result_out,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic                          busy,
  output logic [$clog2(WD_DEPTH):0]     w_count,
  output logic                          w_full,
  output logic                          w_empty,
  output logic                          sat,
  output logic                          err
);

  localparam int unsigned AW = $clog2(WD_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned SW = ACC_WIDTH + 1;

  state_e                       state_q;
  mode_e                        mode_q;
  logic [CW-1:0]                klen_q;
  logic [CW-1:0]                cnt_q;
  logic [CW-1:0]                w_count_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic [DATA_WIDTH-1:0]        right_out_q;
  logic                         right_valid_q;
  logic [DATA_WIDTH-1:0]        result_q;
  logic                         result_valid_q;
  logic                         sat_q;
  logic                         err_q;
  logic [DATA_WIDTH-1:0]        wd [WD_DEPTH];

  logic                         left_xfer;
  logic                         wr_ok;
  logic                         start_ok;
  logic                         mult_en;
  logic                         mult_in_valid;
  logic [DATA_WIDTH-1:0]        weight;
  logic [PW-1:0]                mult_prod;
  logic                         mult_out_valid;
  logic                         mult_active;
  logic signed [SatInWidth-1:0] prod_wide;
  logic signed [SatInWidth-1:0] prod_sat;
  logic                         prod_ovf;
  logic signed [SW-1:0]         fin_sum;
  logic signed [SatInWidth-1:0] fin_wide;
  logic signed [SatInWidth-1:0] fin_sat;
  logic                         fin_ovf;

  // Handshakes, start qualification and saturation of both result sources.
  always_comb begin
    // An unaccepted result freezes the multiplier, so no new activations may enter.
    mult_en       = !result_valid_q || result_ready;
    left_ready    = (state_q == StRun) && mult_en;
    left_xfer     = left_valid && left_ready;
    top_ready     = (state_q == StDrain) && (mode_q == ModeMac) && !mult_active;
    wr_ok         = (state_q == StLoad) && data_in_valid && !w_full;
    mult_in_valid = left_xfer && ((mode_q == ModeMac) || (mode_q == ModeElem));
    weight        = wd[cnt_q[AW-1:0]];
    start_ok      = (k_len != '0) && (k_len <= CW'(WD_DEPTH));
    if (((mode_e'(mode) == ModeMac) || (mode_e'(mode) == ModeElem)) && (k_len > w_count_q)) begin
      start_ok = 1'b0;
    end
    prod_wide = SatInWidth'($signed(mult_prod));
    prod_sat  = sat_to_width(prod_wide, DATA_WIDTH);
    prod_ovf  = sat_overflow(prod_wide, DATA_WIDTH);
    fin_sum   = SW'(acc_q) + SW'($signed(top_in));
    fin_wide  = SatInWidth'(fin_sum);
    fin_sat   = sat_to_width(fin_wide, DATA_WIDTH);
    fin_ovf   = sat_overflow(fin_wide, DATA_WIDTH);
  end

  sa_mult_pipe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .en       (mult_en),
    .a        (left_in),
    .b        (weight),
    .in_valid (mult_in_valid),
    .prod     (mult_prod),
    .out_valid(mult_out_valid),
    .active   (mult_active)
  );

  // Weight storage; contents are only meaningful below w_count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      wd[w_count_q[AW-1:0]] <= data_in;
    end
  end

  // Controller, forwarding, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      mode_q         <= ModeLoad;
      klen_q         <= '0;
      cnt_q          <= '0;
      w_count_q      <= '0;
      acc_q          <= '0;
      right_out_q    <= '0;
      right_valid_q  <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sat_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      right_valid_q <= left_xfer;
      if (left_xfer) begin
        right_out_q <= left_in;
      end

      if (data_in_valid && !wr_ok) begin
        err_q <= 1'b1;
      end
      if (wr_ok) begin
        w_count_q <= w_count_q + CW'(1);
      end

      if (mult_en) begin
        if (mult_out_valid && (mode_q == ModeElem)) begin
          result_q       <= DATA_WIDTH'(prod_sat);
          result_valid_q <= 1'b1;
          if (prod_ovf) begin
            sat_q <= 1'b1;
          end
        end else begin
          result_valid_q <= 1'b0;
        end
        if (mult_out_valid && (mode_q == ModeMac)) begin
          acc_q <= acc_q + ACC_WIDTH'($signed(mult_prod));
        end
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            if (start_ok) begin
              mode_q  <= mode_e'(mode);
              klen_q  <= k_len;
              cnt_q   <= '0;
              acc_q   <= '0;
              state_q <= (mode_e'(mode) == ModeLoad) ? StLoad : StRun;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_full) begin
            state_q <= StIdle;
          end else if (data_in_valid) begin
            cnt_q <= cnt_q + CW'(1);
            if ((cnt_q + CW'(1) == klen_q) || (w_count_q + CW'(1) == CW'(WD_DEPTH))) begin
              state_q <= StIdle;
            end
          end
        end
        StRun: begin
          if (left_xfer) begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q + CW'(1) == klen_q) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          unique case (mode_q)
            ModeMac: begin
              if (top_valid && top_ready) begin
                result_q       <= DATA_WIDTH'(fin_sat);
                result_valid_q <= 1'b1;
                if (fin_ovf) begin
                  sat_q <= 1'b1;
                end
                state_q <= StHold;
              end
            end
            ModeElem: begin
              if (!mult_active && (!result_valid_q || result_ready)) begin
                state_q <= StIdle;
              end
            end
            ModePass: state_q <= StIdle;
            ModeLoad: state_q <= StIdle;
          endcase
        end
        StHold: begin
          if (result_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign right_out    = right_out_q;
  assign right_valid  = right_valid_q;
  assign result_out   = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != StIdle);
  assign w_count      = w_count_q;
  assign w_full       = (w_count_q == CW'(WD_DEPTH));
  assign w_empty      = (w_count_q == '0);
  assign sat          = sat_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sa_cell_pipe.sv
// Directed and randomized bench for sa_cell_pipe against a queue-based arithmetic model.
module tb_sa_cell_pipe;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        start;
  logic [4:0]  k_len;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic [15:0] left_in;
  logic        left_valid;
  logic        left_ready;
  logic [15:0] top_in;
  logic        top_valid;
  logic        top_ready;
  logic [15:0] right_out;
  logic        right_valid;
  logic [15:0] result_out;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic [4:0]  w_count;
  logic        w_full;
  logic        w_empty;
  logic        sat;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Model state: weights held by the cell, sticky flags, activation vector for next op.
  int wq[$];
  int lq[$];
  bit sat_exp;
  bit err_exp;

  sa_cell_pipe #(
    .DATA_WIDTH(16),
    .ACC_WIDTH (40),
    .WD_DEPTH  (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .start        (start),
    .k_len        (k_len),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .left_in      (left_in),
    .left_valid   (left_valid),
    .left_ready   (left_ready),
    .top_in       (top_in),
    .top_valid    (top_valid),
    .top_ready    (top_ready),
    .right_out    (right_out),
    .right_valid  (right_valid),
    .result_out   (result_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .w_count      (w_count),
    .w_full       (w_full),
    .w_empty      (w_empty),
    .sat          (sat),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > 32767) begin
      sat_exp = 1'b1;
      return 32767;
    end else if (v < -32768) begin
      sat_exp = 1'b1;
      return -32768;
    end
    return v;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic fill_lq();
    lq.delete();
    for (int i = 0; i < 16; i++) lq.push_back(rnd16());
  endtask

  task automatic idle_inputs();
    start = 1'b0; mode = 2'd0; k_len = 5'd0; data_in = 16'd0; data_in_valid = 1'b0;
    left_in = 16'd0; left_valid = 1'b0; top_in = 16'd0; top_valid = 1'b0;
    result_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_right_out"}, 64'(right_out), 64'(0));
    chk({tag, "_right_valid"}, 64'(right_valid), 64'(0));
    chk({tag, "_result_out"}, 64'(result_out), 64'(0));
    chk({tag, "_result_valid"}, 64'(result_valid), 64'(0));
    chk({tag, "_left_ready"}, 64'(left_ready), 64'(0));
    chk({tag, "_top_ready"}, 64'(top_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_w_empty"}, 64'(w_empty), 64'(1));
    chk({tag, "_w_full"}, 64'(w_full), 64'(0));
    chk({tag, "_w_count"}, 64'(w_count), 64'(0));
    chk({tag, "_sat"}, 64'(sat), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1 check_reset_values(tag);
    wq.delete();
    sat_exp = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_w_count"}, 64'(w_count), 64'(wq.size()));
    chk({tag, "_w_full"}, 64'(w_full), 64'(wq.size() == 16));
    chk({tag, "_w_empty"}, 64'(w_empty), 64'(wq.size() == 0));
    chk({tag, "_sat"}, 64'(sat), 64'(sat_exp));
    chk({tag, "_err"}, 64'(err), 64'(err_exp));
  endtask

  // LOAD of n words taken from lq.
  task automatic load_words(input int n);
    @(negedge clk);
    mode = 2'd0; k_len = 5'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      data_in_valid = 1'b1;
      data_in = 16'(lq[i]);
      if (wq.size() < 16) wq.push_back(lq[i]);
      else err_exp = 1'b1;
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("load_busy", 64'(busy), 64'(0));
    check_flags("load");
  endtask

  // Start that must be rejected: cell stays idle and err is raised.
  task automatic bad_start(input int md, input int k);
    @(negedge clk);
    mode = 2'(md); k_len = 5'(k); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    err_exp = 1'b1;
    #1;
    chk("bad_start_busy", 64'(busy), 64'(0));
    chk("bad_start_err", 64'(err), 64'(err_exp));
  endtask

  // MAC/ELEM/PASS operation over lq[0..k-1]; hold = result cycles refused before accepting.
  task automatic run_op(input int md, input int k, input int top, input int hold, input bit gaps);
    int     expq[$];
    int     got[$];
    longint s;
    int     idx;
    int     cyc;
    int     held;
    int     fwd_v;
    bit     fwd_p;
    bit     top_done;
    if (md == 1) begin
      s = longint'(top);
      for (int i = 0; i < k; i++) s += longint'(lq[i]) * longint'(wq[i]);
      expq.push_back(int'(clamp(s)));
    end else if (md == 2) begin
      for (int i = 0; i < k; i++) expq.push_back(int'(clamp(longint'(lq[i]) * longint'(wq[i]))));
    end
    @(negedge clk);
    mode = 2'(md); k_len = 5'(k); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0; held = 0; fwd_v = 0; fwd_p = 1'b0;
    top_done = (md != 1);
    while (cyc < 400) begin
      chk("right_valid", 64'(right_valid), 64'(fwd_p));
      if (fwd_p) chk("right_out", 64'($signed(right_out)), 64'(fwd_v));
      if (!busy && !result_valid && idx == k && top_done) break;
      result_ready = (held < hold) ? 1'b0 : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      left_valid   = (idx < k) && (!gaps || $urandom_range(0, 3) != 0);
      left_in      = (idx < k) ? 16'(lq[idx]) : 16'($urandom);
      top_valid    = !top_done && idx == k;
      top_in       = 16'(top);
      #1;
      if (result_valid && result_ready) got.push_back(int'($signed(result_out)));
      if (result_valid && !result_ready) begin
        held++;
        chk("left_ready_stall", 64'(left_ready), 64'(0));
      end
      fwd_p = left_valid && left_ready;
      if (fwd_p) begin
        fwd_v = int'($signed(left_in));
        idx++;
      end
      if (top_valid && top_ready) top_done = 1'b1;
      cyc++;
      @(negedge clk);
    end
    left_valid = 1'b0; top_valid = 1'b0; result_ready = 1'b0;
    chk("op_done_busy", 64'(busy), 64'(0));
    chk("result_count", 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      chk($sformatf("result_%0d", i), 64'(got[i]), 64'(expq[i]));
    end
    check_flags("op");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    sat_exp = 1'b0;
    err_exp = 1'b0;
    do_reset("reset0");

    // Small MAC: 1+2+3+4 plus partial sum 5.
    lq = '{1, 2, 3, 4};
    load_words(4);
    lq = '{1, 1, 1, 1};
    run_op(1, 4, 5, 0, 1'b0);

    // Rejected starts: zero length, length beyond buffer, MAC longer than loaded weights.
    bad_start(1, 0);
    bad_start(3, 17);
    bad_start(1, 5);
    check_flags("after_bad");

    // ELEM with the consumer refusing results for five cycles.
    do_reset("reset_elem");
    lq = '{3, -2};
    load_words(2);
    lq = '{7, 7};
    run_op(2, 2, 0, 5, 1'b0);

    // MAC product above the 16-bit range saturates.
    do_reset("reset_sat");
    lq = '{32767};
    load_words(1);
    lq = '{32767};
    run_op(1, 1, 0, 0, 1'b0);

    // Reset in the middle of a MAC after two of four transfers.
    do_reset("reset_mid");
    fill_lq();
    load_words(4);
    fill_lq();
    @(negedge clk);
    mode = 2'd1; k_len = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      left_valid = 1'b1;
      left_in = 16'(lq[i]);
      #1 chk("mid_left_ready", 64'(left_ready), 64'(1));
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1 check_reset_values("mid_rst");
    wq.delete(); sat_exp = 1'b0; err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    top_valid = 1'b1; result_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_result_valid", 64'(result_valid), 64'(0));
      chk("post_rst_right_valid", 64'(right_valid), 64'(0));
    end
    idle_inputs();

    // PASS forwards 9, 8, 7 and produces no result.
    lq = '{9, 8, 7};
    run_op(3, 3, 0, 0, 1'b0);

    // Fill the buffer, then one extra word is dropped and flagged.
    do_reset("reset_full");
    fill_lq();
    load_words(16);
    @(negedge clk);
    data_in_valid = 1'b1; data_in = 16'hdead;
    @(negedge clk);
    data_in_valid = 1'b0;
    err_exp = 1'b1;
    check_flags("overfill");
    fill_lq();
    run_op(2, 16, 0, 0, 1'b0);

    // Random mix of loads and operations with random back-pressure and gaps.
    do_reset("reset_rand");
    for (int it = 0; it < 14; it++) begin
      int r;
      r = int'($urandom_range(0, 3));
      fill_lq();
      if (r == 0 || wq.size() == 0) begin
        load_words(int'($urandom_range(1, 8)));
      end else if (r == 3) begin
        run_op(3, int'($urandom_range(1, 16)), 0, 0, 1'b1);
      end else begin
        run_op(r, int'($urandom_range(1, wq.size())), rnd16(), int'($urandom_range(0, 3)), 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_cell_pipe.md
SA_CELL_PIPE -- requirements
Module: sa_cell_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed two's-complement operand/result width.
REQ-002 Parameter ACC_WIDTH, default 40: signed accumulator width; SHALL be >= 2*DATA_WIDTH+$clog2(WD_DEPTH).
REQ-003 Parameter WD_DEPTH, default 16: weight buffer entries, power of two >= 2.
REQ-004 Port list (name direction width meaning):
- clk in 1 clock; rst in 1 asynchronous active-high reset
- mode in 2 0=LOAD, 1=MAC, 2=ELEM, 3=PASS; sampled only on start
- start in 1 one-cycle command strobe; k_len in $clog2(WD_DEPTH)+1 operation length
- data_in in DATA_WIDTH / data_in_valid in 1 weight stream
- left_in in DATA_WIDTH / left_valid in 1 / left_ready out 1 activation stream
- top_in in DATA_WIDTH / top_valid in 1 / top_ready out 1 incoming partial sum
- right_out out DATA_WIDTH / right_valid out 1 activation forwarded east
- result_out out DATA_WIDTH / result_valid out 1 / result_ready in 1 result stream
- busy out 1; w_count out $clog2(WD_DEPTH)+1; w_full out 1; w_empty out 1
- sat out 1 sticky saturation flag; err out 1 sticky protocol-error flag

Function
REQ-005 FSM states SHALL be IDLE, LOAD, RUN, DRAIN, HOLD; busy=1 in every state except IDLE.
REQ-006 In IDLE, start with k_len in 1..WD_DEPTH SHALL go to LOAD (mode 0) or RUN (modes 1-3); start with k_len=0 or k_len>WD_DEPTH SHALL be ignored and set err; start outside IDLE SHALL be ignored.
REQ-007 LOAD: each data_in_valid cycle writes wd[w_count], w_count++; after k_len writes, or on reaching WD_DEPTH, return to IDLE next cycle.
REQ-008 data_in_valid while w_full, or outside LOAD, SHALL be dropped and set err.
REQ-009 w_full=(w_count==WD_DEPTH); w_empty=(w_count==0); start in mode 1/2 with k_len>w_count SHALL be ignored and set err.
REQ-010 RUN: left transfer = left_valid && left_ready; left_ready=1 in RUN unless HOLD back-pressure applies (REQ-015).
REQ-011 Every left transfer in RUN (all modes) SHALL drive right_out=left_in, right_valid=1 the next cycle; right_valid=0 otherwise.
REQ-012 Weight read pointer starts at 0 on start, increments per left transfer; RUN exits to DRAIN after k_len transfers.
REQ-013 Multiplier is two pipeline stages: product of left_in*wd[rptr] valid two cycles after the transfer; full 2*DATA_WIDTH signed product.
REQ-014 MAC: accumulator cleared on start, adds sign-extended product in cycle 3 after each transfer; DRAIN waits until pipeline empty, then asserts top_ready; on top_valid computes acc+sext(top_in), saturates to DATA_WIDTH, enters HOLD.
REQ-015 ELEM: each product saturated to DATA_WIDTH and presented on result_out at transfer+3; result_valid held until result_ready; left_ready=0 while a result is pending with result_ready=0, so no result is ever lost.
REQ-016 PASS: no multiply, no result; only REQ-011 forwarding; DRAIN ends immediately.
REQ-017 HOLD: result_valid=1, result_out stable until result_ready=1, then result_valid=0 and FSM to IDLE same edge.
REQ-018 Saturation: value above max -> 2^(DATA_WIDTH-1)-1, below min -> -2^(DATA_WIDTH-1); either SHALL set sat.
REQ-019 Weights persist across operations; LOAD always appends at w_count; only reset empties the buffer.

Reset
REQ-020 rst SHALL asynchronously force IDLE, clear w_count, pointers, accumulator, pipeline valids, sat, err.
REQ-021 Reset values: right_out=0, right_valid=0, result_out=0, result_valid=0, left_ready=0, top_ready=0, busy=0, w_empty=1, w_full=0.
REQ-022 Reset mid-operation SHALL discard in-flight products and pending results with no output valid after release.

Structure
REQ-023 Shared package sa_pkg SHALL hold mode enum (LOAD/MAC/ELEM/PASS), FSM state enum and the saturate-to-width function.
REQ-024 Pipelined multiplier SHALL be sub-module sa_mult_pipe (parameter DATA_WIDTH, 2-cycle latency, valid in/out).

Verification
REQ-025 Load 4 weights {1,2,3,4}, MAC k_len=4, left {1,1,1,1}, top_in=5 -> single result_out=15, w_count=4 throughout.
REQ-026 ELEM k_len=2 with weights {3,-2}, left {7,7}, result_ready=0 for 5 cycles -> left_ready low, results 21 then -14 both delivered in order.
REQ-027 DATA_WIDTH=16, weight 32767, MAC left 32767, top_in 0 -> result_out=32767, sat=1.
REQ-028 Load 16 words then one extra data_in_valid -> w_full=1, w_count=16, err=1, buffer unchanged.
REQ-029 Assert rst during RUN after 2 of 4 transfers -> all outputs at reset values immediately, w_empty=1, no result_valid after release.
REQ-030 PASS k_len=3 left {9,8,7} -> right_out 9,8,7 each one cycle later, result_valid never asserted.
